// File: rtl/clk_divider.sv
// -----------------------------------------------------------------------------
// clk_divider
//   Programmable integer clock divider. A free-running NUM_FF-bit counter wraps
//   every TOP+1 input clocks and drives a registered, glitch-free square wave.
//   The output is an ordinary logic signal, not a clock-tree net.
//
//   Build option: define CLK_DIV_TICK_EN to add the one-clock wrap strobe
//   output 'tick'. The behaviour of 'sig' is the same with or without it.
//
// Parameters
//   NUM_FF  counter width in flip-flops (TOP < 2**NUM_FF)
//   TOP     terminal count; output period = TOP+1 input clocks (TOP >= 1)
//
// Ports
//   clk   in   input clock, rising-edge active
//   rst   in   asynchronous active-low reset (0 = reset)
//   sig   out  divided output, registered; high for HALF clocks per period
//   tick  out  registered wrap strobe (only with CLK_DIV_TICK_EN)
// -----------------------------------------------------------------------------
module clk_divider #(
  parameter int unsigned NUM_FF = 10,
  parameter int unsigned TOP    = 19
) (
  input  logic clk,
  input  logic rst,
  output logic sig
`ifdef CLK_DIV_TICK_EN
  ,
  output logic tick
`endif
);

  // High-phase length: floor((TOP+1)/2); odd periods get the extra clock low.
  localparam int unsigned HALF = (TOP + 1) / 2;

  localparam logic [NUM_FF-1:0] TOP_C  = NUM_FF'(TOP);
  localparam logic [NUM_FF-1:0] HALF_C = NUM_FF'(HALF);
  localparam logic [NUM_FF-1:0] ONE_C  = NUM_FF'(1);

  // Parameter sanity checks at elaboration
  if (NUM_FF < 1) begin : g_err_num_ff
    $error("clk_divider: NUM_FF must be >= 1");
  end
  if (TOP < 1) begin : g_err_top_min
    $error("clk_divider: TOP must be >= 1");
  end
  if ((NUM_FF < 32) && (64'(TOP) >= (64'd1 << NUM_FF))) begin : g_err_top_max
    $error("clk_divider: TOP must be < 2**NUM_FF");
  end

  logic [NUM_FF-1:0] r_cnt;
  logic              r_sig;
  logic              w_wrap;

  // Exact compare against TOP; the counter never relies on natural overflow.
  assign w_wrap = (r_cnt == TOP_C);

  // Period counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + ONE_C;
    end
  end

  // Square-wave output, one clock behind the counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sig <= 1'b0;
    end else begin
      r_sig <= (r_cnt < HALF_C);
    end
  end

  assign sig = r_sig;

`ifdef CLK_DIV_TICK_EN
  logic r_tick;

  // Wrap strobe: high for the single clock after cnt reaches TOP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
    end
  end

  assign tick = r_tick;
`endif

endmodule

// File: tb/tb_clk_divider.sv
// -----------------------------------------------------------------------------
// tb_clk_divider
//   Directed bench for clk_divider. Four instances share clock and reset:
//   TOP=19/NUM_FF=10, TOP=4/NUM_FF=3, TOP=1/NUM_FF=1, TOP=7/NUM_FF=3.
//   Expected output after reset-release edge k: ((k-1) mod (TOP+1)) < HALF.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clk_divider;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic sig19, sig4, sig1, sig7;
  logic tick19, tick4, tick1, tick7;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

`ifndef CLK_DIV_TICK_EN
  assign tick19 = 1'b0;
  assign tick4  = 1'b0;
  assign tick1  = 1'b0;
  assign tick7  = 1'b0;
`endif

  clk_divider #(.NUM_FF(10), .TOP(19)) u_div19 (
    .clk(clk), .rst(rst), .sig(sig19)
`ifdef CLK_DIV_TICK_EN
    , .tick(tick19)
`endif
  );

  clk_divider #(.NUM_FF(3), .TOP(4)) u_div4 (
    .clk(clk), .rst(rst), .sig(sig4)
`ifdef CLK_DIV_TICK_EN
    , .tick(tick4)
`endif
  );

  clk_divider #(.NUM_FF(1), .TOP(1)) u_div1 (
    .clk(clk), .rst(rst), .sig(sig1)
`ifdef CLK_DIV_TICK_EN
    , .tick(tick1)
`endif
  );

  clk_divider #(.NUM_FF(3), .TOP(7)) u_div7 (
    .clk(clk), .rst(rst), .sig(sig7)
`ifdef CLK_DIV_TICK_EN
    , .tick(tick7)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Hand-derived reference: sig after edge k for period p, high length half
  function automatic logic exp_sig(input int k, input int p, input int half);
    return (((k - 1) % p) < half);
  endfunction

  function automatic logic exp_tick(input int k, input int p);
    return (((k - 1) % p) == (p - 1));
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_sig19"}, 32'(sig19), 32'd0);
    check({tag, "_sig4"},  32'(sig4),  32'd0);
    check({tag, "_sig1"},  32'(sig1),  32'd0);
    check({tag, "_sig7"},  32'(sig7),  32'd0);
`ifdef CLK_DIV_TICK_EN
    check({tag, "_tick19"}, 32'(tick19), 32'd0);
    check({tag, "_tick4"},  32'(tick4),  32'd0);
`endif
  endtask

  // Run n edges after a reset release, checking every instance each edge
  task automatic run_seq(input int n);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("d19_k%0d", k), 32'(sig19), 32'(exp_sig(k, 20, 10)));
      check($sformatf("d4_k%0d",  k), 32'(sig4),  32'(exp_sig(k, 5, 2)));
      check($sformatf("d1_k%0d",  k), 32'(sig1),  32'(exp_sig(k, 2, 1)));
      check($sformatf("d7_k%0d",  k), 32'(sig7),  32'(exp_sig(k, 8, 4)));
`ifdef CLK_DIV_TICK_EN
      check($sformatf("t19_k%0d", k), 32'(tick19), 32'(exp_tick(k, 20)));
      check($sformatf("t4_k%0d",  k), 32'(tick4),  32'(exp_tick(k, 5)));
`endif
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held from time zero: outputs known before any clock edge
    rst = 1'b0;
    #2;
    check_all_zero("rst_t0");
    repeat (3) begin
      @(posedge clk);
      #1;
      check_all_zero("rst_hold");
    end

    // Release between edges; 205 edges ends in a TOP=19 high phase
    @(negedge clk);
    rst = 1'b1;
    run_seq(205);
    check("pre_rst_high19", 32'(sig19), 32'd1);

    // Asynchronous assert between edges: outputs drop without a clock
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all_zero("async_hold");
    end

    // Restart from cnt=0: full high phase again
    @(negedge clk);
    rst = 1'b1;
    run_seq(45);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
